// File: rtl/ascon_regs_pkg.sv
// Shared definitions for the Ascon-128 AXI4-Lite register file: register
// offsets, CTRL/STATUS bit positions, response codes and FSM state types.
package ascon_regs_pkg;

    localparam int unsigned REG_OFF_W = 7;

    localparam logic [REG_OFF_W-1:0] OFF_CTRL   = 7'h00;
    localparam logic [REG_OFF_W-1:0] OFF_STATUS = 7'h04;
    localparam logic [REG_OFF_W-1:0] OFF_KEY0   = 7'h10;
    localparam logic [REG_OFF_W-1:0] OFF_KEY1   = 7'h14;
    localparam logic [REG_OFF_W-1:0] OFF_KEY2   = 7'h18;
    localparam logic [REG_OFF_W-1:0] OFF_KEY3   = 7'h1C;
    localparam logic [REG_OFF_W-1:0] OFF_NONCE0 = 7'h20;
    localparam logic [REG_OFF_W-1:0] OFF_NONCE1 = 7'h24;
    localparam logic [REG_OFF_W-1:0] OFF_NONCE2 = 7'h28;
    localparam logic [REG_OFF_W-1:0] OFF_NONCE3 = 7'h2C;
    localparam logic [REG_OFF_W-1:0] OFF_DIN0   = 7'h30;
    localparam logic [REG_OFF_W-1:0] OFF_DIN1   = 7'h34;
    localparam logic [REG_OFF_W-1:0] OFF_DOUT0  = 7'h38;
    localparam logic [REG_OFF_W-1:0] OFF_DOUT1  = 7'h3C;
    localparam logic [REG_OFF_W-1:0] OFF_TAG0   = 7'h40;
    localparam logic [REG_OFF_W-1:0] OFF_TAG1   = 7'h44;
    localparam logic [REG_OFF_W-1:0] OFF_TAG2   = 7'h48;
    localparam logic [REG_OFF_W-1:0] OFF_TAG3   = 7'h4C;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_MODE     = 1;
    localparam int unsigned CTRL_LAST     = 2;
    localparam int unsigned CTRL_DONE_CLR = 3;
    localparam int unsigned CTRL_IRQ_EN   = 4;

    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_DONE = 1;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Expand a 4-bit byte strobe into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi4_lite.sv
// AXI4-Lite bus bundle; clock (ack) and active-low reset (aresetn) travel with it.
interface axi4_lite #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input logic ack,
    input logic aresetn
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport s (
        input  ack, aresetn,
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ascon_axi_regs.sv
// AXI4-Lite register file in front of the Ascon-128 core: key/nonce/data/control
// registers, start handshake, result capture and busy/done status.
// Optional `irq` output is built when ASCON_REGS_IRQ_EN is defined.
module ascon_axi_regs
    import ascon_regs_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    axi4_lite.s            bus,
    output logic           core_start,
    output logic           core_mode,
    output logic           core_last,
    output logic [127:0]   core_key,
    output logic [127:0]   core_nonce,
    output logic [63:0]    core_din,
`ifdef ASCON_REGS_IRQ_EN
    output logic           irq,
`endif
    input  logic           core_busy,
    input  logic           core_done,
    input  logic [63:0]    core_dout,
    input  logic [127:0]   core_tag
);

    if (DATA_WIDTH != 32) begin : g_dw_check
        $error("ascon_axi_regs: only DATA_WIDTH = 32 is supported");
    end

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic                  aw_hs, ar_hs;
    logic [REG_OFF_W-1:0]  waddr, raddr;
    logic [31:0]           wmask;
    logic                  start_req, ctrl_wr_en;
    logic                  wr_err, wr_ctrl, wr_key, wr_nonce, wr_din;
    logic [31:0]           rd_word;
    logic                  rd_err;

    logic [3:0][31:0]      key_q, nonce_q;
    logic [1:0][31:0]      din_q;
    logic [63:0]           dout_q;
    logic [127:0]          tag_q;
    logic                  done_q;
    logic                  irq_en_q;

    logic                  unused_bits;
    assign unused_bits = ^{bus.awaddr[ADDRESS_WIDTH-1:7], bus.awaddr[1:0],
                           bus.araddr[ADDRESS_WIDTH-1:7], bus.araddr[1:0],
                           bus.awprot, bus.arprot};

    assign waddr      = {bus.awaddr[6:2], 2'b00};
    assign raddr      = {bus.araddr[6:2], 2'b00};
    assign wmask      = strb_mask(bus.wstrb);
    assign start_req  = bus.wstrb[0] & bus.wdata[CTRL_START];
    assign ctrl_wr_en = aw_hs & wr_ctrl & bus.wstrb[0];

    assign core_key   = {key_q[0], key_q[1], key_q[2], key_q[3]};
    assign core_nonce = {nonce_q[0], nonce_q[1], nonce_q[2], nonce_q[3]};
    assign core_din   = {din_q[0], din_q[1]};

    // Write FSM state register
    always_ff @(posedge bus.ack or negedge bus.aresetn) begin
        if (!bus.aresetn) wr_state <= W_IDLE;
        else              wr_state <= wr_next;
    end

    // Write FSM: joint AW/W acceptance, then hold the response until taken
    always_comb begin
        wr_next     = wr_state;
        aw_hs       = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (bus.awvalid && bus.wvalid) begin
                    bus.awready = 1'b1;
                    bus.wready  = 1'b1;
                    aw_hs       = 1'b1;
                    wr_next     = W_RESP;
                end
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Write decode: target select and error classification
    always_comb begin
        wr_err   = 1'b0;
        wr_ctrl  = 1'b0;
        wr_key   = 1'b0;
        wr_nonce = 1'b0;
        wr_din   = 1'b0;
        case (waddr)
            OFF_CTRL: begin
                if (start_req && core_busy) wr_err  = 1'b1;
                else                        wr_ctrl = 1'b1;
            end
            OFF_KEY0, OFF_KEY1, OFF_KEY2, OFF_KEY3: begin
                if (core_busy) wr_err = 1'b1;
                else           wr_key = 1'b1;
            end
            OFF_NONCE0, OFF_NONCE1, OFF_NONCE2, OFF_NONCE3: begin
                if (core_busy) wr_err   = 1'b1;
                else           wr_nonce = 1'b1;
            end
            OFF_DIN0, OFF_DIN1: begin
                if (core_busy) wr_err = 1'b1;
                else           wr_din = 1'b1;
            end
            default: wr_err = 1'b1;
        endcase
    end

    // Register updates, start pulse, result capture and sticky done
    always_ff @(posedge bus.ack or negedge bus.aresetn) begin
        if (!bus.aresetn) begin
            bus.bresp  <= OKAY;
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            core_last  <= 1'b0;
            key_q      <= '0;
            nonce_q    <= '0;
            din_q      <= '0;
            dout_q     <= '0;
            tag_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            core_start <= 1'b0;
            if (aw_hs) bus.bresp <= wr_err ? SLVERR : OKAY;
            if (ctrl_wr_en) begin
                core_start <= bus.wdata[CTRL_START];
                core_mode  <= bus.wdata[CTRL_MODE];
                core_last  <= bus.wdata[CTRL_LAST];
                if (bus.wdata[CTRL_START] || bus.wdata[CTRL_DONE_CLR]) done_q <= 1'b0;
            end
            if (aw_hs && wr_key)
                key_q[bus.awaddr[3:2]] <= (key_q[bus.awaddr[3:2]] & ~wmask) | (bus.wdata & wmask);
            if (aw_hs && wr_nonce)
                nonce_q[bus.awaddr[3:2]] <= (nonce_q[bus.awaddr[3:2]] & ~wmask) | (bus.wdata & wmask);
            if (aw_hs && wr_din)
                din_q[bus.awaddr[2]] <= (din_q[bus.awaddr[2]] & ~wmask) | (bus.wdata & wmask);
            // Completion wins over a same-cycle clear
            if (core_done) begin
                done_q <= 1'b1;
                dout_q <= core_dout;
                tag_q  <= core_tag;
            end
        end
    end

`ifdef ASCON_REGS_IRQ_EN
    // Interrupt enable storage and registered interrupt output
    always_ff @(posedge bus.ack or negedge bus.aresetn) begin
        if (!bus.aresetn) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ctrl_wr_en) irq_en_q <= bus.wdata[CTRL_IRQ_EN];
            irq <= done_q & irq_en_q;
        end
    end
`else
    assign irq_en_q = 1'b0;
`endif

    // Read FSM state register
    always_ff @(posedge bus.ack or negedge bus.aresetn) begin
        if (!bus.aresetn) rd_state <= R_IDLE;
        else              rd_state <= rd_next;
    end

    // Read FSM: accept address when idle, hold data until taken
    always_comb begin
        rd_next     = rd_state;
        ar_hs       = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                bus.arready = 1'b1;
                if (bus.arvalid) begin
                    ar_hs   = 1'b1;
                    rd_next = R_DATA;
                end
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                if (bus.rready) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read mux over the register map
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (raddr)
            OFF_CTRL: begin
                rd_word[CTRL_MODE]   = core_mode;
                rd_word[CTRL_LAST]   = core_last;
                rd_word[CTRL_IRQ_EN] = irq_en_q;
            end
            OFF_STATUS: begin
                rd_word[STATUS_BUSY] = core_busy;
                rd_word[STATUS_DONE] = done_q;
            end
            OFF_KEY0, OFF_KEY1, OFF_KEY2, OFF_KEY3:         rd_word = key_q[raddr[3:2]];
            OFF_NONCE0, OFF_NONCE1, OFF_NONCE2, OFF_NONCE3: rd_word = nonce_q[raddr[3:2]];
            OFF_DIN0, OFF_DIN1:                             rd_word = din_q[raddr[2]];
            OFF_DOUT0: rd_word = dout_q[63:32];
            OFF_DOUT1: rd_word = dout_q[31:0];
            OFF_TAG0:  rd_word = tag_q[127:96];
            OFF_TAG1:  rd_word = tag_q[95:64];
            OFF_TAG2:  rd_word = tag_q[63:32];
            OFF_TAG3:  rd_word = tag_q[31:0];
            default:   rd_err  = 1'b1;
        endcase
    end

    // Read data/response captured at the AR handshake
    always_ff @(posedge bus.ack or negedge bus.aresetn) begin
        if (!bus.aresetn) begin
            bus.rdata <= '0;
            bus.rresp <= OKAY;
        end else if (ar_hs) begin
            bus.rdata <= rd_word;
            bus.rresp <= rd_err ? SLVERR : OKAY;
        end
    end

endmodule

// File: tb/tb_ascon_axi_regs.sv
// Directed testbench for ascon_axi_regs; define ASCON_REGS_IRQ_EN to cover irq.
module tb_ascon_axi_regs;

    logic         clk;
    logic         rst_n;
    logic         core_start, core_mode, core_last;
    logic [127:0] core_key, core_nonce;
    logic [63:0]  core_din;
    logic         core_busy, core_done;
    logic [63:0]  core_dout;
    logic [127:0] core_tag;
`ifdef ASCON_REGS_IRQ_EN
    logic         irq;
`endif

    int tests = 0;
    int fails = 0;

    axi4_lite #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus_if (.ack(clk), .aresetn(rst_n));

    ascon_axi_regs dut (
        .bus        (bus_if),
        .core_start (core_start),
        .core_mode  (core_mode),
        .core_last  (core_last),
        .core_key   (core_key),
        .core_nonce (core_nonce),
        .core_din   (core_din),
`ifdef ASCON_REGS_IRQ_EN
        .irq        (irq),
`endif
        .core_busy  (core_busy),
        .core_done  (core_done),
        .core_dout  (core_dout),
        .core_tag   (core_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic pulse_done, output logic [1:0] resp, output logic started);
        bit ok;
        resp = 2'bxx;
        started = 1'bx;
        @(posedge clk); #1;
        bus_if.awvalid = 1'b1; bus_if.wvalid = 1'b1;
        bus_if.awaddr = addr; bus_if.wdata = data; bus_if.wstrb = strb;
        if (pulse_done) core_done = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.awready && bus_if.wready) ok = 1'b1;
            else begin @(posedge clk); #1; core_done = 1'b0; end
        end
        @(posedge clk); #1;
        bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0; core_done = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL write_handshake_timeout addr %08h", addr);
            return;
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.bvalid) begin ok = 1'b1; resp = bus_if.bresp; started = core_start; end
        end
        @(posedge clk); #1;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL write_bvalid_timeout addr %08h", addr);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ok;
        data = 'x;
        resp = 2'bxx;
        @(posedge clk); #1;
        bus_if.arvalid = 1'b1; bus_if.araddr = addr;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.arready) ok = 1'b1;
            else @(posedge clk);
        end
        @(posedge clk); #1;
        bus_if.arvalid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL read_handshake_timeout addr %08h", addr);
            return;
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.rvalid) begin ok = 1'b1; data = bus_if.rdata; resp = bus_if.rresp; end
        end
        @(posedge clk); #1;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL read_rvalid_timeout addr %08h", addr);
        end
    endtask

    task automatic pulse_core_done(input logic [63:0] dout, input logic [127:0] tag);
        @(posedge clk); #1;
        core_dout = dout; core_tag = tag; core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [1:0]  rs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({core_start, core_mode, core_last} !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl_outs: got %b expected 000", {core_start, core_mode, core_last});
        end
        tests++;
        if ({core_key, core_nonce, core_din} !== 320'd0) begin
            fails++; $display("FAIL reset_core_data: got nonzero key/nonce/din expected 0");
        end
        tests++;
        if ({bus_if.bvalid, bus_if.rvalid, bus_if.bresp, bus_if.rresp, bus_if.rdata} !== 38'd0) begin
            fails++; $display("FAIL reset_bus_outs: got bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%08h expected all 0",
                              bus_if.bvalid, bus_if.rvalid, bus_if.bresp, bus_if.rresp, bus_if.rdata);
        end
`ifdef ASCON_REGS_IRQ_EN
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        axi_read(32'h04, rd, rs);
        tests++;
        if (rd !== 32'h0 || rs !== 2'b00) begin
            fails++; $display("FAIL reset_status_read: got %08h/%b expected 00000000/00", rd, rs);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        st;
        axi_write(32'h10, 32'h01234567, 4'b0011, 1'b0, rs, st);
        tests++;
        if (rs !== 2'b00) begin fails++; $display("FAIL key0_wr_resp: got %b expected 00", rs); end
        axi_read(32'h10, rd, rs);
        tests++;
        if (rd !== 32'h00004567) begin fails++; $display("FAIL key0_strb_read: got %08h expected 00004567", rd); end
        tests++;
        if (core_key[127:96] !== 32'h00004567 || core_key[95:0] !== 96'd0) begin
            fails++; $display("FAIL core_key_word0: got %032h expected 00004567000000000000000000000000", core_key);
        end
        axi_write(32'h2C, 32'hDEADBEEF, 4'b1100, 1'b0, rs, st);
        axi_read(32'h2C, rd, rs);
        tests++;
        if (rd !== 32'hDEAD0000 || core_nonce[31:0] !== 32'hDEAD0000) begin
            fails++; $display("FAIL nonce3_strb: got rd=%08h core=%08h expected DEAD0000", rd, core_nonce[31:0]);
        end
    endtask

    task automatic test_start_busy();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        st;
        axi_write(32'h30, 32'hCAFEF00D, 4'hF, 1'b0, rs, st);
        axi_write(32'h00, 32'h3, 4'hF, 1'b0, rs, st);
        tests++;
        if (st !== 1'b1 || rs !== 2'b00) begin
            fails++; $display("FAIL start_pulse: got start=%b resp=%b expected 1/00", st, rs);
        end
        tests++;
        if (core_start !== 1'b0 || core_mode !== 1'b1 || core_last !== 1'b0) begin
            fails++; $display("FAIL start_after: got start=%b mode=%b last=%b expected 0/1/0", core_start, core_mode, core_last);
        end
        axi_read(32'h00, rd, rs);
        tests++;
        if (rd !== 32'h2) begin fails++; $display("FAIL ctrl_read: got %08h expected 00000002", rd); end
        core_busy = 1'b1;
        axi_write(32'h30, 32'h11111111, 4'hF, 1'b0, rs, st);
        tests++;
        if (rs !== 2'b10) begin fails++; $display("FAIL din_busy_resp: got %b expected 10", rs); end
        axi_read(32'h30, rd, rs);
        tests++;
        if (rd !== 32'hCAFEF00D || core_din[63:32] !== 32'hCAFEF00D) begin
            fails++; $display("FAIL din_busy_keep: got rd=%08h core=%08h expected CAFEF00D", rd, core_din[63:32]);
        end
        axi_write(32'h00, 32'h1, 4'hF, 1'b0, rs, st);
        tests++;
        if (rs !== 2'b10 || st !== 1'b0) begin
            fails++; $display("FAIL start_busy: got resp=%b start=%b expected 10/0", rs, st);
        end
        axi_read(32'h04, rd, rs);
        tests++;
        if (rd !== 32'h1) begin fails++; $display("FAIL status_busy: got %08h expected 00000001", rd); end
        core_busy = 1'b0;
    endtask

    task automatic test_done();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        st;
        pulse_core_done(64'h0123456789ABCDEF, {16{8'hA5}});
        for (int i = 0; i < 4; i++) begin
            axi_read(32'h40 + 32'(i * 4), rd, rs);
            tests++;
            if (rd !== 32'hA5A5A5A5 || rs !== 2'b00) begin
                fails++; $display("FAIL tag%0d_read: got %08h/%b expected A5A5A5A5/00", i, rd, rs);
            end
        end
        axi_read(32'h3C, rd, rs);
        tests++;
        if (rd !== 32'h89ABCDEF) begin fails++; $display("FAIL dout1_read: got %08h expected 89ABCDEF", rd); end
        axi_read(32'h04, rd, rs);
        tests++;
        if (rd !== 32'h2) begin fails++; $display("FAIL status_done: got %08h expected 00000002", rd); end
        axi_write(32'h00, 32'h8, 4'hF, 1'b1, rs, st);
        axi_read(32'h04, rd, rs);
        tests++;
        if (rd !== 32'h2) begin fails++; $display("FAIL done_set_wins: got %08h expected 00000002", rd); end
        axi_write(32'h00, 32'h8, 4'hF, 1'b0, rs, st);
        axi_read(32'h04, rd, rs);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL done_clr: got %08h expected 00000000", rd); end
        pulse_core_done(64'h0123456789ABCDEF, {16{8'hA5}});
        axi_write(32'h00, 32'h1, 4'hF, 1'b0, rs, st);
        axi_read(32'h04, rd, rs);
        tests++;
        if (rd !== 32'h0 || st !== 1'b1) begin
            fails++; $display("FAIL start_clears_done: got status=%08h start=%b expected 00000000/1", rd, st);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        st;
        axi_read(32'h50, rd, rs);
        tests++;
        if (rd !== 32'h0 || rs !== 2'b10) begin fails++; $display("FAIL unmapped_read: got %08h/%b expected 00000000/10", rd, rs); end
        axi_read(32'h08, rd, rs);
        tests++;
        if (rs !== 2'b10) begin fails++; $display("FAIL hole_read: got resp %b expected 10", rs); end
        axi_write(32'h38, 32'hFFFFFFFF, 4'hF, 1'b0, rs, st);
        tests++;
        if (rs !== 2'b10) begin fails++; $display("FAIL ro_write_resp: got %b expected 10", rs); end
        axi_read(32'h38, rd, rs);
        tests++;
        if (rd !== 32'h01234567) begin fails++; $display("FAIL ro_write_keep: got %08h expected 01234567", rd); end
    endtask

    task automatic test_bresp_hold();
        logic [31:0] rd;
        logic [1:0]  rs;
        @(posedge clk); #1;
        bus_if.bready = 1'b0;
        bus_if.awvalid = 1'b1; bus_if.wvalid = 1'b1;
        bus_if.awaddr = 32'h18; bus_if.wdata = 32'h11112222; bus_if.wstrb = 4'hF;
        @(posedge clk); #1;
        bus_if.wdata = 32'h33334444;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus_if.bvalid !== 1'b1 || bus_if.awready !== 1'b0) begin
                fails++; $display("FAIL bresp_hold_%0d: got bvalid=%b awready=%b expected 1/0", i, bus_if.bvalid, bus_if.awready);
            end
        end
        @(posedge clk); #1;
        bus_if.bready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (bus_if.bvalid !== 1'b1) begin fails++; $display("FAIL second_write_bvalid: got %b expected 1", bus_if.bvalid); end
        @(posedge clk); #1;
        axi_read(32'h18, rd, rs);
        tests++;
        if (rd !== 32'h33334444) begin fails++; $display("FAIL second_write_data: got %08h expected 33334444", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [1:0]  rs;
        @(posedge clk); #1;
        bus_if.arvalid = 1'b1; bus_if.araddr = 32'h14;
        bus_if.awvalid = 1'b1; bus_if.wvalid = 1'b1;
        bus_if.awaddr = 32'h14; bus_if.wdata = 32'h55AA55AA; bus_if.wstrb = 4'hF;
        @(posedge clk); #1;
        bus_if.arvalid = 1'b0; bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (bus_if.bvalid !== 1'b1 || bus_if.rvalid !== 1'b1 || bus_if.rdata !== 32'h0) begin
            fails++; $display("FAIL concurrent_rw: got bvalid=%b rvalid=%b rdata=%08h expected 1/1/00000000",
                              bus_if.bvalid, bus_if.rvalid, bus_if.rdata);
        end
        @(posedge clk); #1;
        axi_read(32'h14, rd, rs);
        tests++;
        if (rd !== 32'h55AA55AA || core_key[95:64] !== 32'h55AA55AA) begin
            fails++; $display("FAIL concurrent_rw_after: got rd=%08h core=%08h expected 55AA55AA", rd, core_key[95:64]);
        end
    endtask

`ifdef ASCON_REGS_IRQ_EN
    task automatic test_irq();
        logic [1:0] rs;
        logic       st;
        axi_write(32'h00, 32'h18, 4'hF, 1'b0, rs, st);
        @(posedge clk); #1;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_latency_early: got %b expected 0", irq); end
        @(negedge clk);
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b expected 1", irq); end
        axi_write(32'h00, 32'h18, 4'hF, 1'b0, rs, st);
        @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_clr: got %b expected 0", irq); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        core_busy = 1'b0; core_done = 1'b0; core_dout = '0; core_tag = '0;
        bus_if.awvalid = 1'b0; bus_if.awaddr = '0; bus_if.awprot = '0;
        bus_if.wvalid = 1'b0; bus_if.wdata = '0; bus_if.wstrb = '0; bus_if.bready = 1'b1;
        bus_if.arvalid = 1'b0; bus_if.araddr = '0; bus_if.arprot = '0; bus_if.rready = 1'b1;
        test_reset();
        test_strobe();
        test_start_busy();
        test_done();
        test_errors();
        test_bresp_hold();
        test_back_to_back();
`ifdef ASCON_REGS_IRQ_EN
        test_irq();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ascon_axi_regs.md
# ascon_axi_regs

AXI4-Lite subordinate register file that sits directly downstream of the `axi4_lite` bus, through its `s` modport, and in front of the Ascon-128 core. It decodes single-beat reads and writes into key, nonce, data and control registers, and drives the core's start handshake. It also captures the output block and tag on completion and exposes busy/done status to software.

## Interface
- ADDRESS_WIDTH, 32, AXI address width; only bits [6:2] are decoded.
- DATA_WIDTH, 32, AXI data width; only 32 is supported (elaboration error otherwise).
- ack  input  1  clock, carried in the `axi4_lite.s` bus port.
- aresetn  input  1  asynchronous active-low reset, carried in the bus port.
- bus  interface  —  `axi4_lite.s` modport: AR/R/AW/W/B channels; `arprot`/`awprot` are ignored.
- core_start  output  1  one-cycle start pulse to the core.
- core_mode  output  1  0 = encrypt, 1 = decrypt.
- core_last  output  1  marks the current data block as the final one.
- core_key  output  128  key, word 0 in bits [127:96].
- core_nonce  output  128  nonce, word 0 in bits [127:96].
- core_din  output  64  input data block.
- core_busy  input  1  core is processing.
- core_done  input  1  one-cycle completion pulse.
- core_dout  input  64  output block, valid with `core_done`.
- core_tag  input  128  tag, valid with `core_done`.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL (RW): bit0 START (write-1 pulse, reads 0); bit1 MODE; bit2 LAST; bit3 DONE_CLR (write-1, reads 0); bit4 IRQ_EN.
  - 0x04 STATUS (RO): bit0 busy, driven by `core_busy`; bit1 done, sticky.
  - 0x10–0x1C KEY0–3 (RW).
  - 0x20–0x2C NONCE0–3 (RW).
  - 0x30–0x34 DIN0–1 (RW).
  - 0x38–0x3C DOUT0–1 (RO).
  - 0x40–0x4C TAG0–3 (RO).
- Write FSM states W_IDLE and W_RESP:
  - In W_IDLE, `awready` and `wready` are both 1 only when `awvalid && wvalid`. The address and data are accepted in that same cycle and the FSM moves to W_RESP.
  - In W_RESP, `bvalid` is held at 1 until `bready`, then the FSM returns to W_IDLE.
- Read FSM states R_IDLE and R_DATA:
  - `arready` = 1 in R_IDLE. On the handshake, `rdata`/`rresp` are registered and the FSM moves to R_DATA.
  - In R_DATA, `rvalid` is held at 1 until `rready`.
- `wstrb` applies per byte to RW registers. Byte lanes with strobe 0 are unchanged.
- Responses are OKAY (2'b00) or SLVERR (2'b10).
- SLVERR cases:
  - Unmapped offset; reads return 0.
  - Write to an RO register; no effect.
  - Write to KEY/NONCE/DIN or CTRL.START while `core_busy`; the write is discarded entirely.
- On `core_done`: DOUT and TAG capture `core_dout`/`core_tag`, and done is set.
- Simultaneous `core_done` and DONE_CLR: set wins.
- Writing START while idle: `core_start` pulses, and STATUS.done clears in the same cycle.
- Reads and writes proceed independently and may complete in the same cycle.

## Timing
- Reset (asynchronous): both FSMs go to IDLE, and every register and output goes to 0. This includes `bvalid`, `rvalid`, `rdata`, `bresp`, `rresp`, `core_*` and `irq`.
- Reset mid-transaction aborts it with no response. Reset release is sampled on the next `ack` edge.
- Write latency: `bvalid` rises 1 cycle after the AW/W handshake. The register update is visible to a read in that same cycle.
- Read latency: `rvalid` rises 1 cycle after the AR handshake. `rdata` reflects register contents at handshake time.
- `core_start` rises 1 cycle after the accepting AW/W handshake and lasts exactly 1 cycle.
- DOUT/TAG/done update 1 cycle after `core_done`.
- Throughput: at most one write per 2 cycles and one read per 2 cycles.

## Configuration
- `ASCON_REGS_IRQ_EN` defined:
  - Output `irq` is present: `irq` = STATUS.done & CTRL.IRQ_EN, registered, reset 0.
- `ASCON_REGS_IRQ_EN` undefined:
  - No `irq` port.
  - CTRL.IRQ_EN is not stored, reads 0, and writes are ignored with OKAY.

## Structure
- Package `ascon_regs_pkg`:
  - byte-offset localparams for every register;
  - CTRL/STATUS bit-index constants;
  - `resp_t` enum (OKAY, SLVERR);
  - `wr_state_t` and `rd_state_t` enums.
- Single module, no sub-module. The read mux and write decode are local always blocks.

## Test plan
- Reset with bus idle -> all outputs 0; read STATUS returns 0x0 with OKAY.
- Write KEY0=0x01234567 with wstrb=4'b0011, then read -> 0x00004567; `core_key[127:96]`=0x00004567.
- Write CTRL=0x3 -> `core_start` pulses 1 cycle, `core_mode`=1. Drive `core_busy`=1, then write DIN0 -> SLVERR and DIN0 unchanged.
- `core_done` pulse with `core_tag`=0xA5…A5 -> TAG0–3 read 0xA5A5A5A5 and STATUS.done=1. DONE_CLR in the same cycle as a second `core_done` -> done stays 1.
- Read 0x50 -> rdata 0, SLVERR. Write 0x38 -> SLVERR. Hold `bready`=0 for 5 cycles -> `bvalid` stays high and `awready` stays 0.
- With `ASCON_REGS_IRQ_EN`: IRQ_EN=1, then `core_done` -> `irq`=1 two cycles later; DONE_CLR -> `irq`=0.
